ysyx_23060208_ifu_ctrl: RTL and testbench
=========================================

Name: ysyx_23060208_ifu_ctrl

Overview:
- Instruction-fetch controller that sequences the PC register.
- Drives the PC register's write enable and next-PC value, issues AXI4-Lite-style read-address/read-data transactions to instruction memory, and hands fetched instructions to the decode stage over a valid/ready handshake.
- Accepts redirects (branch/jump/trap) from execute.
- Raises a fetch fault on a bus error or response timeout.

Parameters:
- DATA_WIDTH, 32, width of PC, addresses and instruction word.
- PC_STEP, 4, sequential PC increment.
- RESP_TIMEOUT, 255, max cycles in DATA without rvalid before fault; 0 disables the timeout.

Ports:
- clock  in  1  system clock
- reset  in  1  reset, asynchronous, active-low (0 = reset)
- pc  in  DATA_WIDTH  current PC from PC register
- pc_wen  out  1  PC register write enable
- next_pc  out  DATA_WIDTH  value written to PC register when pc_wen=1
- araddr  out  DATA_WIDTH  fetch address
- arvalid  out  1  read-address valid
- arready  in  1  read-address ready
- rdata  in  DATA_WIDTH  read data
- rresp  in  2  read response, 0 = OKAY
- rvalid  in  1  read-data valid
- rready  out  1  read-data ready
- inst  out  DATA_WIDTH  instruction to decode
- inst_pc  out  DATA_WIDTH  address of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts
- redirect_valid  in  1  execute requests PC redirect
- redirect_pc  in  DATA_WIDTH  redirect target
- fetch_fault  out  1  fetch error pending
- fault_pc  out  DATA_WIDTH  PC of faulting fetch

Behaviour:
- Reset (reset=0, async): state=BOOT; flush=0; timeout counter=0.
  - All outputs 0: pc_wen, arvalid, rready, inst_valid, fetch_fault, inst, inst_pc, araddr, fault_pc.
- The PC register holds reset_vector-PC_STEP out of reset.
  - BOOT lasts one cycle: pc_wen=1, next_pc=pc+PC_STEP, then go to ADDR.
- ADDR:
  - On entry, araddr is registered from pc (the updated value) and arvalid=1.
  - araddr and arvalid stay stable until arready=1.
  - On arvalid&arready: arvalid drops next cycle; go to DATA.
- DATA:
  - rready=1; counter increments each cycle with rvalid=0.
  - rvalid=1 with flush=1: data discarded, flush cleared, go to ADDR.
  - rvalid=1, rresp!=0, no flush: fetch_fault=1, fault_pc=araddr, go to FAULT.
  - rvalid=1, rresp==0: inst=rdata, inst_pc=araddr, inst_valid=1 next cycle, go to DELIVER.
  - Counter reaching RESP_TIMEOUT (nonzero) without rvalid: go to FAULT, fault_pc=araddr.
    - rready stays 1 in FAULT, so the late response is sunk.
  - Counter clears on leaving DATA.
- DELIVER:
  - inst_valid=1; inst and inst_pc are held stable until accepted.
  - On inst_ready=1: pc_wen=1, next_pc=pc+PC_STEP, inst_valid=0 next cycle, go to ADDR.
- FAULT:
  - fetch_fault=1 held; no bus requests issued.
  - Exit only via redirect.
  - A late rvalid is accepted and ignored (rready=1).
- Redirect (redirect_valid=1) in any state:
  - Same cycle: pc_wen=1, next_pc=redirect_pc. It has priority over the sequential increment.
  - BOOT: go to ADDR (no +PC_STEP).
  - ADDR with handshake not yet done: address phase is completed unchanged, flush=1; response is discarded in DATA, then ADDR re-issues.
  - ADDR with arready in the same cycle: same as above (flush=1, go to DATA).
  - DATA without rvalid: flush=1.
  - DATA with rvalid in the same cycle: data discarded, go to ADDR; no fault even if rresp!=0.
  - DELIVER: inst_valid=0 next cycle and inst dropped, even if inst_ready=1 that cycle; go to ADDR.
  - FAULT: fetch_fault=0 next cycle, go to ADDR.
- Arithmetic: pc+PC_STEP truncated to DATA_WIDTH; wrap at all-ones is allowed silently.
- At most one outstanding read; no speculation beyond one instruction.
- pc_wen is a single-cycle pulse per update.

Decomposition:
- Shared package ysyx_23060208_ifu_pkg holds:
  - state enum: BOOT, ADDR, DATA, DELIVER, FAULT
  - RESP_OKAY=2'b00
  - PC_STEP default
- One natural sub-module: ysyx_23060208_ifu_timeout, the resettable saturating response-timeout counter (enable, clear, expired).

Test Plan:
- Boot: release reset with PC register at 0x0EFF_FFFC.
  - Expected: one pc_wen pulse with next_pc=0x0F00_0000, then araddr=0x0F00_0000 with arvalid=1.
- Sequential fetch: arready=1, rvalid one cycle later with rdata=0x0000_0013; inst_ready=1.
  - Expected: inst=0x13, inst_pc=0x0F00_0000, pc_wen with next_pc=0x0F00_0004, next araddr=0x0F00_0004.
- Backpressure: inst_ready=0 for 5 cycles.
  - Expected: inst_valid, inst and inst_pc stable; no pc_wen; arvalid=0 throughout.
- Redirect during DATA: redirect_pc=0x8000_0100 while waiting.
  - Expected: same-cycle pc_wen with next_pc=0x8000_0100; the later rvalid is dropped (no inst_valid); next araddr=0x8000_0100.
- Redirect plus inst_ready in the same DELIVER cycle, target 0x8000_0200.
  - Expected: next_pc=0x8000_0200 (not pc+4), inst_valid drops.
- Faults:
  - rresp=2'b10 at pc 0x0F00_0008 -> fetch_fault=1, fault_pc=0x0F00_0008, held until redirect.
  - RESP_TIMEOUT=8 with no rvalid -> fault after 8 DATA cycles.
  - Async reset asserted mid-DATA -> all outputs 0 immediately.

Source files
------------

// File: rtl/ysyx_23060208_ifu_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ysyx_23060208_ifu_pkg;

    typedef enum logic [2:0] {
        BOOT,
        ADDR,
        DATA,
        DELIVER,
        FAULT
    } ifu_state_e;

    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam int         PC_STEP_DEFAULT = 4;

    // Counter width able to hold values 0..limit (at least one bit).
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/ysyx_23060208_ifu_timeout.sv
// Saturating response-timeout counter. expired_o flags the cycle in which
// the LIMIT-th consecutive enabled cycle occurs; LIMIT=0 disables it.
module ysyx_23060208_ifu_timeout
    import ysyx_23060208_ifu_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic en_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int            CW      = cnt_width(LIMIT);
    localparam bit            ENABLED = (LIMIT != 0);
    localparam logic [CW-1:0] MAX_V   = CW'(LIMIT);
    localparam logic [CW-1:0] LAST_V  = CW'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear wins, otherwise count enabled cycles up to LIMIT.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != MAX_V)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = ENABLED && en_i && (count_q >= LAST_V);

endmodule

// File: rtl/ysyx_23060208_ifu_ctrl.sv
// Instruction-fetch controller: sequences the PC register, issues one
// outstanding instruction read at a time, hands instructions to decode and
// reports bus errors / response timeouts as a held fetch fault.
module ysyx_23060208_ifu_ctrl
    import ysyx_23060208_ifu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int PC_STEP      = PC_STEP_DEFAULT,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc,
    output logic                  pc_wen,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [DATA_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  fetch_fault,
    output logic [DATA_WIDTH-1:0] fault_pc
);

    ifu_state_e            state_q, state_d;
    logic                  flush_q, flush_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [DATA_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [DATA_WIDTH-1:0] fault_pc_q, fault_pc_d;
    logic [DATA_WIDTH-1:0] inc_pc;
    logic                  upd_pc;
    logic                  tmo_expired;

    // Wraps silently at all-ones.
    assign inc_pc = pc + DATA_WIDTH'(PC_STEP);

    ysyx_23060208_ifu_timeout #(
        .LIMIT(RESP_TIMEOUT)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .en_i     ((state_q == DATA) && !rvalid),
        .clr_i    (state_q != DATA),
        .expired_o(tmo_expired)
    );

    // Next-state, PC update and captured-register logic. A redirect always
    // writes the PC this cycle; araddr is loaded with the PC value that will
    // be visible in ADDR (next_pc when the PC is being written, else pc).
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d    = state_q;
        flush_d    = flush_q;
        araddr_d   = araddr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        fault_pc_d = fault_pc_q;
        upd_pc     = redirect_valid;
        next_pc    = redirect_valid ? redirect_pc : inc_pc;

        unique case (state_q)
            BOOT: begin
                upd_pc   = 1'b1;
                state_d  = ADDR;
                araddr_d = next_pc;
            end
            ADDR: begin
                // The address phase completes unchanged; the response is dropped.
                if (redirect_valid) flush_d = 1'b1;
                if (arready)        state_d = DATA;
            end
            DATA: begin
                if (rvalid) begin
                    if (flush_q || redirect_valid) begin
                        state_d  = ADDR;
                        flush_d  = 1'b0;
                        araddr_d = redirect_valid ? next_pc : pc;
                    end else if (rresp != RESP_OKAY) begin
                        state_d    = FAULT;
                        fault_pc_d = araddr_q;
                    end else begin
                        state_d   = DELIVER;
                        inst_d    = rdata;
                        inst_pc_d = araddr_q;
                    end
                end else if (redirect_valid) begin
                    flush_d = 1'b1;
                end else if (tmo_expired) begin
                    state_d    = FAULT;
                    fault_pc_d = araddr_q;
                    flush_d    = 1'b0;
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    state_d  = ADDR;
                    araddr_d = next_pc;
                end else if (inst_ready) begin
                    upd_pc   = 1'b1;
                    state_d  = ADDR;
                    araddr_d = next_pc;
                end
            end
            FAULT: begin
                if (redirect_valid) begin
                    state_d  = ADDR;
                    araddr_d = next_pc;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State and captured registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT;
            flush_q    <= 1'b0;
            araddr_q   <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
            fault_pc_q <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q    <= state_d;
            flush_q    <= flush_d;
            araddr_q   <= araddr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    // NOTE: BOOT requests a PC write, so the pulse is masked while reset is held.
    assign pc_wen      = reset && upd_pc;
    assign araddr      = araddr_q;
    assign arvalid     = (state_q == ADDR);
    assign rready      = (state_q == DATA) || (state_q == FAULT);
    assign inst        = inst_q;
    assign inst_pc     = inst_pc_q;
    assign inst_valid  = (state_q == DELIVER);
    assign fetch_fault = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_ysyx_23060208_ifu_ctrl.sv
// Directed bench for the fetch controller. Stimulus pushes expected PC
// writes, address handshakes, delivered instructions and faults into
// queues; a monitor on the falling edge pops and compares them.
module tb_ysyx_23060208_ifu_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc;
    logic        pc_wen;
    logic [31:0] next_pc;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    ysyx_23060208_ifu_ctrl #(
        .DATA_WIDTH  (32),
        .PC_STEP     (4),
        .RESP_TIMEOUT(8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .pc            (pc),
        .pc_wen        (pc_wen),
        .next_pc       (next_pc),
        .araddr        (araddr),
        .arvalid       (arvalid),
        .arready       (arready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rvalid        (rvalid),
        .rready        (rready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_fault   (fetch_fault),
        .fault_pc      (fault_pc)
    );

    always #5 clock = ~clock;

    // PC register of the surrounding core: holds reset_vector-4 out of reset.
    always @(posedge clock or negedge reset) begin
        if (!reset)      pc <= 32'h0EFF_FFFC;
        else if (pc_wen) pc <= next_pc;
    end

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] pcw_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] inst_exp_q[$];
    logic [31:0] inst_pc_exp_q[$];
    logic [31:0] fault_q[$];
    logic        fault_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: unexpected event, value 0x%08h", name, act);
    endtask

    // Monitor: compare every DUT-presented event against the queued expectation.
    always @(negedge clock) begin
        if (reset) begin
            if (pc_wen) begin
                if (pcw_q.size() == 0) unexpected("pc_wen", next_pc);
                else check("next_pc", next_pc, pcw_q.pop_front());
            end
            if (arvalid && arready) begin
                if (ar_q.size() == 0) unexpected("ar_handshake", araddr);
                else check("araddr", araddr, ar_q.pop_front());
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (inst_exp_q.size() == 0) unexpected("inst_accept", inst);
                else begin
                    check("inst", inst, inst_exp_q.pop_front());
                    check("inst_pc", inst_pc, inst_pc_exp_q.pop_front());
                end
            end
            if (fetch_fault && !fault_seen) begin
                if (fault_q.size() == 0) unexpected("fetch_fault", fault_pc);
                else check("fault_pc", fault_pc, fault_q.pop_front());
            end
            fault_seen <= fetch_fault;
        end else begin
            fault_seen <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for arvalid, then complete the address handshake.
    task automatic ar_handshake();
        int n;
        n = 0;
        while (!arvalid && n < 20) begin
            tick();
            n++;
        end
        if (!arvalid) unexpected("arvalid_timeout", 32'(n));
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [1:0] resp);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        tick();
        rvalid = 1'b0;
        rresp  = 2'b00;
    endtask

    task automatic push_inst(input logic [31:0] data, input logic [31:0] addr);
        inst_exp_q.push_back(data);
        inst_pc_exp_q.push_back(addr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_wen"},      32'(pc_wen),      32'h0);
        check({tag, "_arvalid"},     32'(arvalid),     32'h0);
        check({tag, "_rready"},      32'(rready),      32'h0);
        check({tag, "_inst_valid"},  32'(inst_valid),  32'h0);
        check({tag, "_fetch_fault"}, 32'(fetch_fault), 32'h0);
        check({tag, "_inst"},        inst,             32'h0);
        check({tag, "_inst_pc"},     inst_pc,          32'h0);
        check({tag, "_araddr"},      araddr,           32'h0);
        check({tag, "_fault_pc"},    fault_pc,         32'h0);
    endtask

    initial begin
        // Watchdog.
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state.
        #2;
        check_all_zero("reset");

        // Boot then sequential fetch.
        pcw_q.push_back(32'h0F00_0000);
        ar_q.push_back(32'h0F00_0000);
        tick();
        reset = 1'b1;
        ar_handshake();
        push_inst(32'h0000_0013, 32'h0F00_0000);
        r_beat(32'h0000_0013, 2'b00);
        pcw_q.push_back(32'h0F00_0004);
        ar_q.push_back(32'h0F00_0004);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Backpressure: decode stalls for five cycles.
        ar_handshake();
        push_inst(32'h0010_0093, 32'h0F00_0004);
        r_beat(32'h0010_0093, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("bp_inst_valid", 32'(inst_valid), 32'h1);
            check("bp_inst", inst, 32'h0010_0093);
            check("bp_inst_pc", inst_pc, 32'h0F00_0004);
            check("bp_arvalid", 32'(arvalid), 32'h0);
            tick();
        end
        pcw_q.push_back(32'h0F00_0008);
        ar_q.push_back(32'h0F00_0008);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;

        // Bus error: fault held, late response sunk, exit via redirect.
        ar_handshake();
        fault_q.push_back(32'h0F00_0008);
        r_beat(32'hDEAD_BEEF, 2'b10);
        for (int i = 0; i < 3; i++) begin
            check("fault_held", 32'(fetch_fault), 32'h1);
            check("fault_no_ar", 32'(arvalid), 32'h0);
            check("fault_rready", 32'(rready), 32'h1);
            tick();
        end
        r_beat(32'h1111_1111, 2'b00);
        check("fault_after_late_r", 32'(fetch_fault), 32'h1);
        check("fault_late_no_inst", 32'(inst_valid), 32'h0);
        pcw_q.push_back(32'h0F00_0100);
        ar_q.push_back(32'h0F00_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0F00_0100;
        tick();
        redirect_valid = 1'b0;
        check("fault_cleared", 32'(fetch_fault), 32'h0);

        // Redirect while waiting in DATA: later response is dropped.
        ar_handshake();
        tick();
        pcw_q.push_back(32'h8000_0100);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        r_beat(32'h0000_1234, 2'b00);
        check("flush_no_inst", 32'(inst_valid), 32'h0);
        check("flush_reissue_arvalid", 32'(arvalid), 32'h1);
        check("flush_reissue_araddr", araddr, 32'h8000_0100);
        ar_q.push_back(32'h8000_0100);
        ar_handshake();

        // Redirect and inst_ready in the same DELIVER cycle.
        r_beat(32'h0000_0073, 2'b00);
        pcw_q.push_back(32'h8000_0200);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("redir_deliver_inst_valid", 32'(inst_valid), 32'h0);
        check("redir_deliver_araddr", araddr, 32'h8000_0200);
        ar_q.push_back(32'h8000_0200);
        ar_handshake();

        // Response timeout (RESP_TIMEOUT=8).
        fault_q.push_back(32'h8000_0200);
        n = 0;
        while (!fetch_fault && n < 20) begin
            tick();
            n++;
        end
        check("timeout_data_cycles", 32'(n), 32'd8);
        pcw_q.push_back(32'h0F00_0010);
        ar_q.push_back(32'h0F00_0010);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0F00_0010;
        tick();
        redirect_valid = 1'b0;

        // Async reset in the middle of DATA.
        ar_handshake();
        check("pre_reset_rready", 32'(rready), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");

        // Boot again after reset.
        @(posedge clock);
        #1;
        pcw_q.push_back(32'h0F00_0000);
        ar_q.push_back(32'h0F00_0000);
        reset = 1'b1;
        ar_handshake();
        tick();
        tick();

        check("pcw_q_drained", 32'(pcw_q.size()), 32'h0);
        check("ar_q_drained", 32'(ar_q.size()), 32'h0);
        check("inst_q_drained", 32'(inst_exp_q.size()), 32'h0);
        check("fault_q_drained", 32'(fault_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
